// File: rtl/fetch_unit.sv
// fetch_unit: bf8b instruction fetch stage. Reads program bytes through the shared
// memory arbiter into a small prefetch queue and hands them to decode/exec with their PC.
`default_nettype none

module fetch_unit #(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic       mem_ready,
  input  logic [7:0] mem_rdata,
  input  logic       redirect,
  input  logic [7:0] redirect_pc,
  output logic       instr_valid,
  output logic [7:0] instr,
  output logic [7:0] instr_pc,
  input  logic       instr_ready
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(QUEUE_DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0]    state;
  logic [7:0]    fetch_pc;
  logic [7:0]    req_addr;
  logic [PW:0]   count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          discard;
  logic          halted;
  logic          req_q;
  logic [7:0]    q_data [QUEUE_DEPTH];
  logic [7:0]    q_pc   [QUEUE_DEPTH];

  logic can_issue;
  logic push;
  logic pop;

  // A stale ready from the previous transaction must never be mistaken for a new completion.
  assign can_issue = !halted && (count < FULL) && !mem_ready && !redirect;
  assign push      = (state == REQ) && mem_ready && !discard && !redirect;
  assign pop       = instr_valid && instr_ready && !redirect;

  assign mem_req     = req_q;
  assign mem_addr    = req_addr;
  assign mem_we      = 1'b0;
  assign mem_wdata   = 8'h00;
  assign instr_valid = (count != '0);
  assign instr       = q_data[rd_ptr];
  assign instr_pc    = q_pc[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= 8'h00;
      req_addr <= 8'h00;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      discard  <= 1'b0;
      halted   <= 1'b0;
      req_q    <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_data[i] <= 8'h00;
        q_pc[i]   <= 8'h00;
      end
    end else begin
      case (state)
        IDLE: begin
          if (can_issue) begin
            req_q    <= 1'b1;
            req_addr <= fetch_pc;
            state    <= REQ;
          end
        end
        REQ: begin
          if (mem_ready) begin
            req_q   <= 1'b0;
            state   <= RELEASE;
            discard <= 1'b0;
          end else if (redirect) begin
            // Arbiter already holds this address; drain the transaction and drop its data.
            discard <= 1'b1;
          end
        end
        RELEASE: begin
          if (!mem_ready) begin
            if (can_issue) begin
              req_q    <= 1'b1;
              req_addr <= fetch_pc;
              state    <= REQ;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase

      if (push) begin
        q_data[wr_ptr] <= mem_rdata;
        q_pc[wr_ptr]   <= req_addr;
        wr_ptr         <= wr_ptr + 1'b1;
        fetch_pc       <= req_addr + 8'd1;
        if (mem_rdata == 8'h00) begin
          halted <= 1'b1;
        end
      end

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      if (redirect) begin
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fetch_pc <= redirect_pc;
        halted   <= 1'b0;
      end else begin
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit with a two-cycle
// arbiter model that can be held off by a competing client.
`default_nettype none

module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic       mem_ready;
  logic [7:0] mem_rdata;
  logic       redirect = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic       instr_valid;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_ready = 1'b0;

  logic [7:0] mem [256];
  logic       busy = 1'b0;
  int         lat;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic [7:0] issue_q [$];
  logic       prev_req = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  int         addr_unstable = 0;

  fetch_unit #(.QUEUE_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) cyc <= cyc + 1;

  // Arbiter: ready two edges after a request is seen, cleared once the request drops.
  always @(posedge clk) begin
    if (rst) begin
      mem_ready <= 1'b0;
      lat       <= 0;
    end else if (mem_ready) begin
      if (!mem_req) mem_ready <= 1'b0;
    end else if (mem_req && !busy) begin
      if (lat == 1) begin
        mem_ready <= 1'b1;
        lat       <= 0;
      end else begin
        lat <= lat + 1;
      end
    end else begin
      lat <= 0;
    end
  end

  always @(negedge clk) begin
    if (mem_req && !prev_req) issue_q.push_back(mem_addr);
    if (mem_req && prev_req && mem_addr !== prev_addr) addr_unstable++;
    prev_req  = mem_req;
    prev_addr = mem_addr;
  end

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) | 8'h80;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    issue_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_req, mem_addr, mem_we, mem_wdata} !== 18'h0) begin
      errors++;
      $display("FAIL reset_mem: req=%b addr=%h we=%b wdata=%h expected all 0", mem_req, mem_addr, mem_we, mem_wdata);
    end
    checks++;
    if ({instr_valid, instr, instr_pc} !== 17'h0) begin
      errors++;
      $display("FAIL reset_instr: valid=%b instr=%h pc=%h expected all 0", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_program();
    bit ok;
    int t [3];
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h2B; exp_b[1] = 8'h3E; exp_b[2] = 8'h00;
    fill_mem();
    mem[0] = 8'h2B; mem[1] = 8'h3E; mem[2] = 8'h00;
    instr_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      wait_valid(ok);
      t[k] = cyc;
      checks++;
      if (!ok || instr !== exp_b[k] || instr_pc !== 8'(k)) begin
        errors++;
        $display("FAIL prog_byte%0d: ok=%b instr=%h pc=%h expected %h pc=%h", k, ok, instr, instr_pc, exp_b[k], 8'(k));
      end
    end
    checks++;
    if (t[1] - t[0] != 5 || t[2] - t[1] != 5) begin
      errors++;
      $display("FAIL prog_spacing: gaps %0d %0d expected 5 5", t[1] - t[0], t[2] - t[1]);
    end
    begin
      int seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (mem_req) seen++;
      end
      checks++;
      if (seen != 0) begin
        errors++;
        $display("FAIL halt_no_req: req cycles=%0d expected 0", seen);
      end
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    fill_mem();
    instr_ready = 1'b0;
    do_reset();
    repeat (60) @(negedge clk);
    checks++;
    if (issue_q.size() != 4 || issue_q[0] !== 8'h00 || issue_q[3] !== 8'h03) begin
      errors++;
      $display("FAIL bp_fill: issues=%0d expected 4 (pc 0..3)", issue_q.size());
    end
    checks++;
    if (instr_valid !== 1'b1 || instr !== 8'h80 || instr_pc !== 8'h00) begin
      errors++;
      $display("FAIL bp_head: valid=%b instr=%h pc=%h expected 1 80 00", instr_valid, instr, instr_pc);
    end
    instr_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_ready = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (issue_q.size() != 5 || issue_q[issue_q.size()-1] !== 8'h04) begin
      errors++;
      $display("FAIL bp_one_more: issues=%0d expected 5 ending at pc 04", issue_q.size());
    end
    checks++;
    if (instr_pc !== 8'h01 || instr !== 8'h81) begin
      errors++;
      $display("FAIL bp_after_pop: instr=%h pc=%h expected 81 01", instr, instr_pc);
    end
  endtask

  task automatic test_redirect_in_req();
    bit ok;
    bit found;
    fill_mem();
    instr_ready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 8'h02 && !mem_ready) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL redir_reach_req: never saw request for pc 02");
    end
    redirect = 1'b1;
    redirect_pc = 8'h40;
    @(posedge clk);
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h02) begin
      errors++;
      $display("FAIL redir_hold: valid=%b req=%b addr=%h expected 0 1 02", instr_valid, mem_req, mem_addr);
    end
    instr_ready = 1'b1;
    wait_valid(ok);
    checks++;
    if (!ok || instr_pc !== 8'h40 || instr !== 8'hC0) begin
      errors++;
      $display("FAIL redir_first: ok=%b instr=%h pc=%h expected C0 40", ok, instr, instr_pc);
    end
    checks++;
    if (issue_q.size() < 4 || issue_q[3] !== 8'h40) begin
      errors++;
      $display("FAIL redir_next_addr: issues=%0d expected 4th issue at pc 40", issue_q.size());
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_redirect_pop();
    bit found;
    fill_mem();
    instr_ready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 8'h03) found = 1'b1;
    end
    checks++;
    if (!found || instr_valid !== 1'b1 || instr_pc !== 8'h00) begin
      errors++;
      $display("FAIL rp_setup: found=%b valid=%b pc=%h expected 1 1 00", found, instr_valid, instr_pc);
    end
    redirect = 1'b1;
    redirect_pc = 8'h80;
    instr_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    redirect = 1'b0;
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rp_flush: valid=%b expected 0", instr_valid);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    fill_mem();
    mem[0] = 8'h00;
    instr_ready = 1'b1;
    do_reset();
    wait_valid(ok);
    checks++;
    if (!ok || instr !== 8'h00 || instr_pc !== 8'h00) begin
      errors++;
      $display("FAIL wrap_halt_byte: ok=%b instr=%h pc=%h expected 00 00", ok, instr, instr_pc);
    end
    repeat (8) @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL wrap_r0: req=%b expected 0", mem_req);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_r1: req=%b addr=%h expected 1 FF", mem_req, mem_addr);
    end
    wait_valid(ok);
    checks++;
    if (!ok || instr !== 8'hFF || instr_pc !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_ff: ok=%b instr=%h pc=%h expected FF FF", ok, instr, instr_pc);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (issue_q.size() < 3 || issue_q[issue_q.size()-1] !== 8'h00) begin
      errors++;
      $display("FAIL wrap_next: issues=%0d expected last issue at pc 00", issue_q.size());
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_contention();
    bit ok;
    fill_mem();
    busy = 1'b1;
    instr_ready = 1'b1;
    do_reset();
    repeat (12) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h00 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL cont_hold: req=%b addr=%h valid=%b expected 1 00 0", mem_req, mem_addr, instr_valid);
    end
    busy = 1'b0;
    wait_valid(ok);
    checks++;
    if (!ok || instr !== 8'h80 || instr_pc !== 8'h00) begin
      errors++;
      $display("FAIL cont_data: ok=%b instr=%h pc=%h expected 80 00", ok, instr, instr_pc);
    end
    instr_ready = 1'b0;
    checks++;
    if (addr_unstable != 0) begin
      errors++;
      $display("FAIL addr_stable: changes while req=%0d expected 0", addr_unstable);
    end
  endtask

  initial begin
    fill_mem();
    test_reset();
    test_program();
    test_backpressure();
    test_redirect_in_req();
    test_redirect_pop();
    test_wrap();
    test_contention();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the bf8b core. It is a read-only client of the shared memory arbiter: it requests program bytes one at a time over the arbiter's request/ready handshake and buffers them in a small prefetch queue. It presents them, tagged with their address, to the decode/exec stage over a valid/ready interface. The exec stage redirects it on taken `[`/`]` branches.

## Interface
- `QUEUE_DEPTH`, 4, prefetch queue entries; power of two, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_req`  out  1  arbiter request line for this client.
- `mem_addr`  out  8  read address; stable for the whole time `mem_req`=1.
- `mem_we`  out  1  tied 0 (read-only client).
- `mem_wdata`  out  8  tied 0.
- `mem_ready`  in  1  arbiter ready bit for this client.
- `mem_rdata`  in  8  memory read data; valid while `mem_ready`=1.
- `redirect`  in  1  one-cycle pulse: flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  8  new fetch address, sampled when `redirect`=1.
- `instr_valid`  out  1  queue head valid.
- `instr`  out  8  queue head opcode byte.
- `instr_pc`  out  8  address the head byte was fetched from.
- `instr_ready`  in  1  consumer accepts head this cycle.

## Operation
- Registers: `fetch_pc`[7:0], `req_addr`[7:0], `count` (0..QUEUE_DEPTH), rd/wr pointers, `discard`, `halted`, FSM state.
- FSM `IDLE`:
  - If !`halted`, `count`<QUEUE_DEPTH, `mem_ready`=0 and `redirect`=0: `mem_req`←1, `req_addr`←`fetch_pc`, go to `REQ`.
  - Otherwise stay in `IDLE`.
- FSM `REQ`:
  - Hold `mem_req`=1 and `mem_addr`.
  - On an edge with `mem_ready`=1: `mem_req`←0, go to `RELEASE`.
  - If `discard`=0 and no redirect on that edge: push {`mem_rdata`, `req_addr`} and set `fetch_pc`←`req_addr`+1 (mod 256, 0xFF wraps to 0x00).
  - If `discard`=1: drop the data and clear `discard`.
- FSM `RELEASE`:
  - Wait until `mem_ready`=0, then go to `IDLE`.
  - `mem_req` is never raised while `mem_ready`=1. This prevents a stale ready from being taken as a new completion.
- Halt: a pushed byte of 0x00 (program terminator) sets `halted`. No further requests are issued until a redirect.
- Pop: edge with `instr_valid`=1 and `instr_ready`=1 advances rd pointer and decrements `count`.
  - Push and pop on the same edge leave `count` unchanged.
- Redirect, on any edge with `redirect`=1:
  - Flush: `count`←0, pointers←0.
  - `fetch_pc`←`redirect_pc`; `halted`←0.
  - A pop on the same edge is ignored.
  - If in `REQ` without `mem_ready`=1, set `discard`←1: the arbiter has already latched the address, so the transaction cannot be aborted and is drained.
  - If in `REQ` with `mem_ready`=1 on the same edge, drop the data and go to `RELEASE`.
- At most one memory transaction is outstanding. Issue is gated on `count`<QUEUE_DEPTH, so a push never overflows.

## Timing
- Reset values:
  - `mem_req`=0, `mem_addr`=0, `mem_we`=0, `mem_wdata`=0.
  - `instr_valid`=0, `instr`=0, `instr_pc`=0 (storage cleared).
  - `fetch_pc`=0, `count`=0, `discard`=0, `halted`=0, state `IDLE`.
- Reset mid-transaction drops `mem_req` on the reset edge. The arbiter shares the same reset.
- `instr*` are driven from the registered queue head; there is no bypass.
- `mem_req` rises at edge E. The arbiter asserts ready after E+2. The byte is pushed at E+3, and `instr_valid`=1 is visible after E+3.
- The arbiter clears ready at E+4. The next request rises at E+5, giving sustained throughput of 1 byte / 5 cycles with an uncontended bus.
- After a redirect at edge R (fetch unit idle): request for `redirect_pc` rises at R+1.

## Test plan
- Reset, program 0x2B,0x3E,0x00 at 0..2, `instr_ready`=1 → consumer sees (0x2B,pc0),(0x3E,pc1),(0x00,pc2), each 5 cycles apart. After that, `mem_req` stays 0 (halted).
- `instr_ready`=0, nonzero memory → exactly QUEUE_DEPTH fetches (pc 0..3), then `mem_req` stays 0. One pop → exactly one more fetch, at pc 4.
- `redirect`=1, `redirect_pc`=0x40, issued while in `REQ` for pc 2 → pc 2 data is never presented, `mem_req` is held until that `mem_ready`, and the next fetch address is 0x40. `instr_pc` 0x40 is the first valid output.
- Redirect on the same edge as a pop with `count`=3 → queue empty next cycle, `instr_valid`=0.
- `fetch_pc`=0xFF → after the fetch of 0xFF, the next `mem_addr`=0x00.
- Second arbiter client (exec stage, higher index) contends → the fetch unit holds `mem_req` and `mem_addr` stable until its own `mem_ready`, and data is correct.
